alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/alu_operand_stage_if.sv | 47 ++++
 rtl/fwd_mux.sv | 45 ++++
 rtl/alu_operand_stage.sv | 121 ++++++++++++
 tb/tb_alu_operand_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: default widths, ALU operation codes
// and the forwarding-source encoding.
package riscv_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned OPCODE_LENGTH = 4;
    localparam int unsigned REG_ADDR_W    = 5;

    // ALU operation codes
    localparam logic [OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
    localparam logic [OPCODE_LENGTH-1:0] ALU_OR  = 4'b0001;
    localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = 4'b0010;
    localparam logic [OPCODE_LENGTH-1:0] ALU_XOR = 4'b0011;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = 4'b0110;
    localparam logic [OPCODE_LENGTH-1:0] ALU_SLT = 4'b0111;

    // Where a forwarded register value comes from
    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_src_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side and ALU-side handshake bundle of the ALU operand stage.
//   master : upstream decode + downstream ALU (drives in_*, out_ready)
//   slave  : the operand stage (drives in_ready, out_*, SrcA/SrcB/Operation)
interface alu_operand_stage_if #(
    parameter int unsigned DATA_WIDTH    = riscv_pkg::DATA_WIDTH,
    parameter int unsigned OPCODE_LENGTH = riscv_pkg::OPCODE_LENGTH,
    parameter int unsigned REG_ADDR_W    = riscv_pkg::REG_ADDR_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_rs1_data;
    logic [DATA_WIDTH-1:0]    in_rs2_data;
    logic [DATA_WIDTH-1:0]    in_imm;
    logic [DATA_WIDTH-1:0]    in_pc;
    logic [REG_ADDR_W-1:0]    in_rs1_addr;
    logic [REG_ADDR_W-1:0]    in_rs2_addr;
    logic [REG_ADDR_W-1:0]    in_rd_addr;
    logic [OPCODE_LENGTH-1:0] in_alu_op;
    logic                     in_use_pc;
    logic                     in_use_imm;
    logic                     in_reg_write;

    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    out_store_data;
    logic [REG_ADDR_W-1:0]    out_rd_addr;
    logic                     out_reg_write;

    modport master (
        output in_valid, in_rs1_data, in_rs2_data, in_imm, in_pc,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_alu_op,
               in_use_pc, in_use_imm, in_reg_write, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation,
               out_store_data, out_rd_addr, out_reg_write
    );

    modport slave (
        input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_pc,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_alu_op,
               in_use_pc, in_use_imm, in_reg_write, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation,
               out_store_data, out_rd_addr, out_reg_write
    );
endinterface

// File: rtl/fwd_mux.sv
// Combinational register-value forwarding select (EX/MEM over MEM/WB).
//   addr           : source register index of the operand
//   stored         : value captured at decode (or refreshed during a stall)
//   exmem_* / memwb_* : in-flight producers
//   data_c         : forwarded operand value
module fwd_mux #(
    parameter int unsigned DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [DATA_WIDTH-1:0] stored,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    output logic [DATA_WIDTH-1:0] data_c
);
    import riscv_pkg::*;

    fwd_src_e src_c;

    // x0 is hardwired zero and is never a forwarding target
    always_comb begin
        src_c = FWD_NONE;
        if (addr != '0) begin
            if (exmem_reg_write && (exmem_rd == addr)) begin
                src_c = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_rd == addr)) begin
                src_c = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        data_c = stored;
        case (src_c)
            FWD_EXMEM: data_c = exmem_result;
            FWD_MEMWB: data_c = memwb_result;
            default:   data_c = stored;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Single-entry operand register between decode and the ALU, with operand
// forwarding applied on the output side and stall-time operand refresh.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decode/ALU handshake bundle (slave side)
//   flush      : drop held and incoming instruction
//   exmem_* / memwb_* : forwarding sources
module alu_operand_stage #(
    parameter int unsigned DATA_WIDTH    = riscv_pkg::DATA_WIDTH,
    parameter int unsigned OPCODE_LENGTH = riscv_pkg::OPCODE_LENGTH,
    parameter int unsigned REG_ADDR_W    = riscv_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_operand_stage_if.slave    bus,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic [DATA_WIDTH-1:0] memwb_result
);
    logic                     valid_q;
    logic [DATA_WIDTH-1:0]    rs1_data_q;
    logic [DATA_WIDTH-1:0]    rs2_data_q;
    logic [DATA_WIDTH-1:0]    imm_q;
    logic [DATA_WIDTH-1:0]    pc_q;
    logic [REG_ADDR_W-1:0]    rs1_addr_q;
    logic [REG_ADDR_W-1:0]    rs2_addr_q;
    logic [REG_ADDR_W-1:0]    rd_addr_q;
    logic [OPCODE_LENGTH-1:0] alu_op_q;
    logic                     use_pc_q;
    logic                     use_imm_q;
    logic                     reg_write_q;

    logic                     in_ready_c;
    logic                     load_c;
    logic [DATA_WIDTH-1:0]    rs1_fwd_c;
    logic [DATA_WIDTH-1:0]    rs2_fwd_c;

    assign in_ready_c = !valid_q || bus.out_ready;
    assign load_c     = bus.in_valid && in_ready_c && !flush;

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .addr            (rs1_addr_q),
        .stored          (rs1_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .data_c          (rs1_fwd_c)
    );

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .addr            (rs2_addr_q),
        .stored          (rs2_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .data_c          (rs2_fwd_c)
    );

    // Entry register: flush beats load, load beats drain; a stalled entry
    // absorbs forwarded values so they outlive the producing instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            alu_op_q    <= '0;
            use_pc_q    <= 1'b0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (load_c) begin
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end

            if (load_c) begin
                rs1_data_q  <= bus.in_rs1_data;
                rs2_data_q  <= bus.in_rs2_data;
                imm_q       <= bus.in_imm;
                pc_q        <= bus.in_pc;
                rs1_addr_q  <= bus.in_rs1_addr;
                rs2_addr_q  <= bus.in_rs2_addr;
                rd_addr_q   <= bus.in_rd_addr;
                alu_op_q    <= bus.in_alu_op;
                use_pc_q    <= bus.in_use_pc;
                use_imm_q   <= bus.in_use_imm;
                reg_write_q <= bus.in_reg_write;
            end else if (valid_q && !bus.out_ready) begin
                rs1_data_q <= rs1_fwd_c;
                rs2_data_q <= rs2_fwd_c;
            end
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = valid_q;
    assign bus.SrcA           = use_pc_q  ? pc_q  : rs1_fwd_c;
    assign bus.SrcB           = use_imm_q ? imm_q : rs2_fwd_c;
    assign bus.out_store_data = rs2_fwd_c;
    assign bus.Operation      = alu_op_q;
    assign bus.out_rd_addr    = rd_addr_q;
    assign bus.out_reg_write  = valid_q && reg_write_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: table-driven back-to-back beats
// with a scoreboard queue, plus hand-written forwarding/stall/flush/reset
// sequences.
module tb_alu_operand_stage;

    typedef struct {
        logic [4:0]  rs1a;
        logic [31:0] rs1d;
        logic [4:0]  rs2a;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  op;
        logic        upc;
        logic        uimm;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] es;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic exmem_reg_write;
    logic memwb_reg_write;
    logic [4:0]  exmem_rd;
    logic [4:0]  memwb_rd;
    logic [31:0] exmem_result;
    logic [31:0] memwb_result;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .memwb_reg_write (memwb_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_rd        (memwb_rd),
        .exmem_result    (exmem_result),
        .memwb_result    (memwb_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    logic m_valid = 1'b0;
    logic pend    = 1'b0;
    exp_t pend_e;
    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] rs1a, input logic [31:0] rs1d,
                                input logic [4:0] rs2a, input logic [31:0] rs2d,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [3:0] op, input logic upc, input logic uimm,
                                input logic [4:0] rd, input logic rw,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [31:0] es);
        vec_t v;
        v.rs1a = rs1a; v.rs1d = rs1d; v.rs2a = rs2a; v.rs2d = rs2d;
        v.imm = imm; v.pc = pc; v.op = op; v.upc = upc; v.uimm = uimm;
        v.rd = rd; v.rw = rw; v.ea = ea; v.eb = eb; v.es = es;
        return v;
    endfunction

    task automatic set_beat(input vec_t v, input logic track);
        bus.in_valid     = 1'b1;
        bus.in_rs1_addr  = v.rs1a;
        bus.in_rs1_data  = v.rs1d;
        bus.in_rs2_addr  = v.rs2a;
        bus.in_rs2_data  = v.rs2d;
        bus.in_imm       = v.imm;
        bus.in_pc        = v.pc;
        bus.in_alu_op    = v.op;
        bus.in_use_pc    = v.upc;
        bus.in_use_imm   = v.uimm;
        bus.in_rd_addr   = v.rd;
        bus.in_reg_write = v.rw;
        pend = track;
        pend_e.a = v.ea; pend_e.b = v.eb; pend_e.s = v.es;
        pend_e.op = v.op; pend_e.rd = v.rd; pend_e.rw = v.rw;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    // Called between edges with inputs settled: check handshake against the
    // model, score any departing beat, then advance the model past the edge.
    task automatic tick();
        logic acc;
        exp_t e;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
        if (!m_valid) check("out_reg_write_idle", 32'(bus.out_reg_write), 32'd0);
        if (m_valid && bus.out_ready && q.size() > 0) begin
            e = q.pop_front();
            check("SrcA", bus.SrcA, e.a);
            check("SrcB", bus.SrcB, e.b);
            check("store_data", bus.out_store_data, e.s);
            check("Operation", 32'(bus.Operation), 32'(e.op));
            check("rd_addr", 32'(bus.out_rd_addr), 32'(e.rd));
            check("reg_write", 32'(bus.out_reg_write), 32'(e.rw));
        end
        acc = bus.in_valid && (!m_valid || bus.out_ready) && !flush;
        if (acc && pend) q.push_back(pend_e);
        if (flush)                   m_valid = 1'b0;
        else if (acc)                m_valid = 1'b1;
        else if (bus.out_ready)      m_valid = 1'b0;
        pend = 1'b0;
    endtask

    initial begin
        // AND=0000 OR=0001 ADD=0010 SUB=0110
        vecs[0] = mk(5'd5, 32'h10, 5'd6, 32'h20, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0,
                     5'd7, 1'b1, 32'h10, 32'h20, 32'h20);
        vecs[1] = mk(5'd1, 32'hDEADBEEF, 5'd2, 32'h5, 32'h7FF, 32'h0, 4'b0110, 1'b0, 1'b1,
                     5'd3, 1'b1, 32'hDEADBEEF, 32'h7FF, 32'h5);
        vecs[2] = mk(5'd4, 32'h11, 5'd0, 32'h99, 32'h4, 32'h1000, 4'b0010, 1'b1, 1'b1,
                     5'd1, 1'b1, 32'h1000, 32'h4, 32'h99);
        vecs[3] = mk(5'd31, 32'hFFFF0000, 5'd30, 32'h00FFFF00, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0,
                     5'd0, 1'b0, 32'hFFFF0000, 32'h00FFFF00, 32'h00FFFF00);
        vecs[4] = mk(5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0, 1'b0,
                     5'd9, 1'b1, 32'h0, 32'h0, 32'h0);

        rst_n = 1'b1;
        flush = 1'b0;
        clear_fwd();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.in_rs1_addr = '0; bus.in_rs1_data = '0; bus.in_rs2_addr = '0;
        bus.in_rs2_data = '0; bus.in_imm = '0; bus.in_pc = '0; bus.in_alu_op = '0;
        bus.in_use_pc = 1'b0; bus.in_use_imm = 1'b0; bus.in_rd_addr = '0;
        bus.in_reg_write = 1'b0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_reg_write", 32'(bus.out_reg_write), 32'd0);
        check("rst_SrcA", bus.SrcA, 32'd0);
        check("rst_SrcB", bus.SrcB, 32'd0);
        check("rst_Operation", 32'(bus.Operation), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Back-to-back beats at full throughput
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); set_beat(vecs[i], 1'b1); #1; tick();
        end
        @(negedge clk); bus.in_valid = 1'b0; #1; tick();
        check("drained", 32'(q.size()), 32'd0);

        // EX/MEM wins over MEM/WB; stall refresh keeps forwarded value
        @(negedge clk); bus.out_ready = 1'b0;
        set_beat(mk(5'd5, 32'h1, 5'd6, 32'h2, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0,
                    5'd8, 1'b1, 32'h0, 32'h0, 32'h0), 1'b0);
        #1; tick();
        @(negedge clk); bus.in_valid = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAAAA;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hBBBB;
        #1; tick();
        check("fwd_prio_SrcA", bus.SrcA, 32'hAAAA);
        check("fwd_prio_SrcB", bus.SrcB, 32'h2);
        check("stall_reg_write", 32'(bus.out_reg_write), 32'd1);
        @(negedge clk); exmem_reg_write = 1'b0; #1; tick();
        check("fwd_memwb_SrcA", bus.SrcA, 32'hBBBB);
        @(negedge clk); clear_fwd(); #1; tick();
        check("stall_hold_SrcA", bus.SrcA, 32'hBBBB);
        @(negedge clk); bus.out_ready = 1'b1; #1; tick();
        check("release_SrcA", bus.SrcA, 32'hBBBB);

        // Three-cycle stall, MEM/WB rs2 value survives producer retirement
        @(negedge clk); bus.out_ready = 1'b0;
        set_beat(mk(5'd5, 32'h10, 5'd6, 32'h20, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0,
                    5'd7, 1'b1, 32'h0, 32'h0, 32'h0), 1'b0);
        #1; tick();
        @(negedge clk); bus.in_valid = 1'b0;
        memwb_reg_write = 1'b1; memwb_rd = 5'd6; memwb_result = 32'h1234;
        #1; tick();
        check("stall1_SrcB", bus.SrcB, 32'h1234);
        @(negedge clk); clear_fwd();
        set_beat(vecs[3], 1'b0);
        #1; tick();
        check("stall2_SrcB", bus.SrcB, 32'h1234);
        @(negedge clk); bus.in_valid = 1'b0; #1; tick();
        check("stall3_SrcB", bus.SrcB, 32'h1234);
        check("stall3_SrcA", bus.SrcA, 32'h10);
        @(negedge clk); bus.out_ready = 1'b1; #1; tick();
        check("stall_rel_SrcB", bus.SrcB, 32'h1234);
        check("stall_rel_store", bus.out_store_data, 32'h1234);

        // x0 never forwarded
        @(negedge clk); bus.out_ready = 1'b0;
        set_beat(mk(5'd0, 32'h0, 5'd0, 32'h55, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0,
                    5'd2, 1'b1, 32'h0, 32'h0, 32'h0), 1'b0);
        #1; tick();
        @(negedge clk); bus.in_valid = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFFFF;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'h77;
        #1; tick();
        check("x0_SrcA", bus.SrcA, 32'h0);
        check("x0_store", bus.out_store_data, 32'h55);
        @(negedge clk); clear_fwd(); bus.out_ready = 1'b1; #1; tick();

        // Flush dominates a same-cycle load
        @(negedge clk); bus.out_ready = 1'b0; set_beat(vecs[0], 1'b0); #1; tick();
        @(negedge clk); bus.out_ready = 1'b1; flush = 1'b1; set_beat(vecs[1], 1'b0); #1; tick();
        @(negedge clk); flush = 1'b0; bus.in_valid = 1'b0; #1; tick();
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_reg_write", 32'(bus.out_reg_write), 32'd0);

        // Reset mid-stall; first edge after release loads
        @(negedge clk); bus.out_ready = 1'b0; set_beat(vecs[1], 1'b0); #1; tick();
        @(negedge clk); bus.in_valid = 1'b0; #1; tick();
        #1 rst_n = 1'b0;
        #1;
        check("rst_stall_valid", 32'(bus.out_valid), 32'd0);
        check("rst_stall_SrcA", bus.SrcA, 32'd0);
        m_valid = 1'b0;
        q.delete();
        @(negedge clk); rst_n = 1'b1; bus.out_ready = 1'b1; set_beat(vecs[2], 1'b1); #1; tick();
        @(negedge clk); bus.in_valid = 1'b0; #1; tick();
        check("post_rst_drained", 32'(q.size()), 32'd0);

        // Reset mid-stream leaves no residual beat
        @(negedge clk); set_beat(vecs[0], 1'b1); #1; tick();
        @(negedge clk); set_beat(vecs[1], 1'b1); #1; tick();
        #1 rst_n = 1'b0;
        #1;
        check("rst_stream_valid", 32'(bus.out_valid), 32'd0);
        check("rst_stream_reg_write", 32'(bus.out_reg_write), 32'd0);
        m_valid = 1'b0;
        q.delete();
        @(negedge clk); rst_n = 1'b1; bus.in_valid = 1'b0; #1; tick();
        @(negedge clk); #1; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
